// File: rtl/video_src_sched.sv
// Frame-aligned AXI4-Stream video source scheduler: forwards s0 or s1 and switches only at frame boundaries.
// Define VIDEO_SRC_SCHED_FILL_EN to add the solid-colour internal generator on req_src=2.
module video_src_sched #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req_src,
    input  logic [23:0] fill_rgb,
    input  logic [23:0] s0_axis_video_tdata,
    input  logic        s0_axis_video_tvalid,
    input  logic        s0_axis_video_tlast,
    input  logic        s0_axis_video_tuser,
    output logic        s0_axis_video_tready,
    input  logic [23:0] s1_axis_video_tdata,
    input  logic        s1_axis_video_tvalid,
    input  logic        s1_axis_video_tlast,
    input  logic        s1_axis_video_tuser,
    output logic        s1_axis_video_tready,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    output logic        m_axis_video_tlast,
    output logic        m_axis_video_tuser,
    input  logic        m_axis_video_tready,
    output logic [1:0]  active_src,
    output logic [15:0] frame_cnt,
    output logic        sof_err
);

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

    typedef enum logic {SYNC, RUN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  active_src_q, active_src_d;
    logic [10:0] pix_q, pix_d;
    logic [9:0]  line_q, line_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        sof_err_q, sof_err_d;

    logic [23:0] sel_data;
    logic        sel_valid, sel_last, sel_user;
    logic        act_ready, acc, restart, req_legal;
    logic [10:0] pix_b;
    logic [9:0]  line_b;

`ifdef VIDEO_SRC_SCHED_FILL_EN
    logic [23:0] fill_q, fill_d;
`else
    logic unused_fill;
    assign unused_fill = ^fill_rgb;
`endif

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        case (active_src_q)
            2'd0: begin
                sel_data  = s0_axis_video_tdata;
                sel_valid = s0_axis_video_tvalid;
                sel_last  = s0_axis_video_tlast;
                sel_user  = s0_axis_video_tuser;
            end
            2'd1: begin
                sel_data  = s1_axis_video_tdata;
                sel_valid = s1_axis_video_tvalid;
                sel_last  = s1_axis_video_tlast;
                sel_user  = s1_axis_video_tuser;
            end
`ifdef VIDEO_SRC_SCHED_FILL_EN
            2'd2: begin
                sel_data  = fill_q;
                sel_valid = 1'b1;
                sel_last  = (pix_q == H_LAST);
                sel_user  = (pix_q == '0) && (line_q == '0);
            end
`endif
            default: ;
        endcase
    end

    assign m_axis_video_tdata  = sel_data;
    assign m_axis_video_tvalid = (state_q == RUN) && sel_valid;
    assign m_axis_video_tlast  = sel_last;
    assign m_axis_video_tuser  = sel_user;

    // While hunting for SOF the active source is drained, but the SOF beat itself is held back for RUN.
    assign act_ready = (state_q == RUN) ? m_axis_video_tready : !(sel_valid && sel_user);
    assign s0_axis_video_tready = !rstn || (active_src_q != 2'd0) || act_ready;
    assign s1_axis_video_tready = !rstn || (active_src_q != 2'd1) || act_ready;

    assign acc     = m_axis_video_tvalid && m_axis_video_tready;
    assign restart = sel_user && ((pix_q != '0) || (line_q != '0));
    assign pix_b   = restart ? '0 : pix_q;
    assign line_b  = restart ? '0 : line_q;

`ifdef VIDEO_SRC_SCHED_FILL_EN
    assign req_legal = (req_src != 2'd3);
`else
    assign req_legal = !req_src[1];
`endif

    always_comb begin
        state_d      = state_q;
        active_src_d = active_src_q;
        pix_d        = pix_q;
        line_d       = line_q;
        frame_cnt_d  = frame_cnt_q;
        sof_err_d    = sof_err_q;
`ifdef VIDEO_SRC_SCHED_FILL_EN
        fill_d       = fill_q;
`endif
        if (state_q == SYNC) begin
            if (sel_valid && sel_user) begin
                state_d = RUN;
            end
        end else if (acc) begin
            if (restart) begin
                sof_err_d = 1'b1;
            end
            if (sel_last) begin
                pix_d = '0;
                if (line_b == V_LAST) begin
                    line_d      = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef VIDEO_SRC_SCHED_FILL_EN
                    fill_d      = fill_rgb;
`endif
                    if (req_legal && (req_src != active_src_q)) begin
                        active_src_d = req_src;
`ifdef VIDEO_SRC_SCHED_FILL_EN
                        state_d = (req_src == 2'd2) ? RUN : SYNC;
`else
                        state_d = SYNC;
`endif
                    end
                end else begin
                    line_d = line_b + 10'd1;
                end
            end else begin
                pix_d  = pix_b + 11'd1;
                line_d = line_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= SYNC;
            active_src_q <= '0;
            pix_q        <= '0;
            line_q       <= '0;
            frame_cnt_q  <= '0;
            sof_err_q    <= 1'b0;
`ifdef VIDEO_SRC_SCHED_FILL_EN
            fill_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            active_src_q <= active_src_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
            frame_cnt_q  <= frame_cnt_d;
            sof_err_q    <= sof_err_d;
`ifdef VIDEO_SRC_SCHED_FILL_EN
            fill_q       <= fill_d;
`endif
        end
    end

    assign active_src = active_src_q;
    assign frame_cnt  = frame_cnt_q;
    assign sof_err    = sof_err_q;

endmodule

// File: doc/video_src_sched.md
VIDEO_SRC_SCHED -- requirements
Module: video_src_sched

Interface
REQ-001 Parameter H_ACTIVE, default 1280, pixels per line (beats per tlast).
REQ-002 Parameter V_ACTIVE, default 720, lines per frame.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 req_src  in  2  requested source: 0=s0, 1=s1, 2=internal fill (fill valid only with macro), 3=reserved (treated as hold current).
REQ-006 fill_rgb  in  24  fill colour {R[23:16],B[15:8],G[7:0]}.
REQ-007 s0_axis_video_tdata/tvalid/tlast/tuser in 24/1/1/1, s0_axis_video_tready out 1: camera stream.
REQ-008 s1_axis_video_tdata/tvalid/tlast/tuser in 24/1/1/1, s1_axis_video_tready out 1: auxiliary stream.
REQ-009 m_axis_video_tdata/tvalid/tlast/tuser out 24/1/1/1, m_axis_video_tready in 1: to colour-space converter.
REQ-010 active_src  out  2  source currently forwarded.
REQ-011 frame_cnt  out  16  completed frames forwarded, wraps 0xFFFF->0.
REQ-012 sof_err  out  1  sticky: tuser seen on active source mid-frame; cleared only by reset.

Function
REQ-013 FSM states SYNC (discard until SOF) and RUN (forward); reset state SYNC with active_src=0.
REQ-014 In SYNC the active source's tready SHALL be 1 and beats discarded; a beat with tvalid&tuser SHALL NOT be consumed but cause SYNC->RUN next cycle.
REQ-015 In RUN, m_axis tdata/tvalid/tlast/tuser SHALL combinationally equal the active source's; active source tready = m_axis_video_tready; zero added latency.
REQ-016 Non-active stream sources SHALL see tready=1 at all times (sunk, never stalled).
REQ-017 In SYNC, m_axis_video_tvalid SHALL be 0.
REQ-018 Pixel counter (11 bits) increments per accepted output beat, clears on accepted tlast; line counter (10 bits) increments per accepted tlast, clears at frame end.
REQ-019 Frame end = accepted beat with tlast while line counter = V_ACTIVE-1; frame_cnt increments that cycle.
REQ-020 req_src SHALL be sampled only at frame end; if it differs from active_src (and is legal), active_src updates and FSM enters SYNC next cycle; otherwise stays RUN.
REQ-021 Accepted tuser beat while pixel or line counter nonzero SHALL set sof_err, reset both counters and continue in RUN treating that beat as first of a new frame.
REQ-022 tlast arriving before pixel counter reaches H_ACTIVE-1 SHALL be forwarded unchanged; line still counted.
REQ-023 req_src change mid-frame SHALL have no effect until frame end; changes back before frame end cancel the switch.

Reset
REQ-024 On rstn low: active_src=0, state SYNC, counters 0, frame_cnt=0, sof_err=0, m_axis_video_tvalid=0, all s*_tready=1.
REQ-025 Reset mid-frame SHALL abandon the frame; after release, output resumes only on next s0 SOF.

Configuration
REQ-026 Macro VIDEO_SRC_SCHED_FILL_EN: when defined, req_src=2 selects internal generator emitting H_ACTIVE x V_ACTIVE frames of fill_rgb, tuser on first beat, tlast on beat H_ACTIVE-1, tvalid=1 continuously, advancing only on m_axis_video_tready; generator enters RUN directly (no SYNC); fill_rgb sampled at frame start.
REQ-027 Without VIDEO_SRC_SCHED_FILL_EN, req_src=2 SHALL be treated as 3 (hold), no generator logic instantiated.

Verification
REQ-028 Reset, s0 sends 3 beats without tuser then SOF -> m_tvalid=0 for first 3, SOF beat first forwarded, active_src=0.
REQ-029 H_ACTIVE=4,V_ACTIVE=2, two s0 frames with m_tready toggling each cycle -> data matches in order, frame_cnt=2, s1_tready=1 throughout.
REQ-030 req_src 0->1 at pixel 2 of line 0 -> switch only after frame end, then SYNC discards s1 until its tuser, frame_cnt unchanged during SYNC.
REQ-031 s0 tuser at line 1 pixel 1 -> sof_err=1, counters restart, frame_cnt increments only after V_ACTIVE full lines.
REQ-032 With FILL_EN, req_src=2, fill_rgb=0x123456, H=4,V=2 -> 8 beats 0x123456, tuser on beat 0, tlast on beats 3 and 7; without macro active_src stays 0.
REQ-033 rstn asserted mid-line -> outputs at REQ-024 values same cycle; after release waits for s0 SOF.
